// File: rtl/uart_tx_sched.sv
// uart_tx_sched: pulls bytes from the TX FIFO and launches them on the UART
// transmitter, with inter-frame gap, flush/drain, frame count and low-watermark irq.
// Optional clear-to-send gating: define UART_TX_SCHED_CTS_EN to add the cts_n input.
module uart_tx_sched #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 64,
    parameter int GAP_CYCLES = 16,
    parameter int LOW_WM     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     flush,
    input  logic                     fifo_empty,
    input  logic [$clog2(DEPTH):0]   fifo_count,
    input  logic [WIDTH-1:0]         fifo_data,
`ifdef UART_TX_SCHED_CTS_EN
    input  logic                     cts_n,
`endif
    output logic                     fifo_rd_en,
    input  logic                     tx_busy,
    output logic                     tx_start,
    output logic [WIDTH-1:0]         tx_data,
    output logic                     sched_busy,
    output logic                     flush_done,
    output logic [15:0]              frames_sent,
    output logic                     lowwm_irq
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LAST_I);
    localparam logic [CW-1:0] LOW_WM_C = CW'(LOW_WM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO,
        S_GAP,
        S_DRAIN
    } state_t;

    state_t state, state_nx;

    logic [GW-1:0] gap_cnt;
    logic          gap_done;
    logic          flush_pend;
    logic          cmp_r;
    logic          cmp_prev;
    logic          cts_ok;

`ifdef UART_TX_SCHED_CTS_EN
    logic cts_s1;
    logic cts_s2;

    // two-flop synchroniser for the asynchronous clear-to-send input
    always_ff @(posedge clk) begin
        if (rst) begin
            cts_s1 <= 1'b1;
            cts_s2 <= 1'b1;
        end else begin
            cts_s1 <= cts_n;
            cts_s2 <= cts_s1;
        end
    end

    assign cts_ok = ~cts_s2;
`else
    assign cts_ok = 1'b1;
`endif

    assign gap_done = (GAP_CYCLES == 0) || (gap_cnt == GAP_LAST);

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state and state-decoded outputs
    always_comb begin
        state_nx   = state;
        fifo_rd_en = 1'b0;
        tx_start   = 1'b0;
        sched_busy = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                if (flush || flush_pend) begin
                    state_nx = S_DRAIN;
                end else if (enable && !fifo_empty && cts_ok) begin
                    state_nx = S_READ;
                end
            end
            S_READ: begin
                fifo_rd_en = !fifo_empty;
                state_nx   = S_LATCH;
            end
            S_LATCH: begin
                state_nx = S_START;
            end
            S_START: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_nx = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (tx_busy) begin
                    state_nx = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!tx_busy) begin
                    state_nx = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_done) begin
                    state_nx = S_IDLE;
                end
            end
            S_DRAIN: begin
                fifo_rd_en = !fifo_empty;
                if (fifo_empty) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // data latch, frame counter, gap timer and pending flush request
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data     <= '0;
            frames_sent <= '0;
            gap_cnt     <= '0;
            flush_pend  <= 1'b0;
            flush_done  <= 1'b0;
        end else begin
            if (state == S_LATCH) begin
                tx_data <= fifo_data;
            end
            if (state == S_WAIT_LO && !tx_busy) begin
                frames_sent <= frames_sent + 16'd1;
            end
            if (state == S_GAP && !gap_done) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
            // a flush seen mid-frame is held until the frame is done
            if (state == S_IDLE || state == S_DRAIN) begin
                flush_pend <= 1'b0;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
            flush_done <= (state == S_DRAIN) && fifo_empty;
        end
    end

    // low-watermark compare history; both start high so an empty FIFO
    // after reset does not look like a downward crossing
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_r    <= 1'b1;
            cmp_prev <= 1'b1;
        end else begin
            cmp_r    <= (fifo_count <= LOW_WM_C);
            cmp_prev <= cmp_r;
        end
    end

    assign lowwm_irq = cmp_r & ~cmp_prev;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed bench with FIFO and transmitter models,
// a cycle table for launch latency and sequences for gap, flush, stop and watermark.
module tb_uart_tx_sched;

    localparam int GAP = 16;
    localparam int PERIOD = 10 + GAP + 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        flush;
    logic        fifo_empty;
    logic [6:0]  fifo_count;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_rd_en;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        sched_busy;
    logic        flush_done;
    logic [15:0] frames_sent;
    logic        lowwm_irq;
`ifdef UART_TX_SCHED_CTS_EN
    logic        cts_n = 1'b0;
`endif

    uart_tx_sched #(
        .WIDTH(8), .DEPTH(64), .GAP_CYCLES(GAP), .LOW_WM(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .flush(flush),
        .fifo_empty(fifo_empty),
        .fifo_count(fifo_count),
        .fifo_data(fifo_data),
`ifdef UART_TX_SCHED_CTS_EN
        .cts_n(cts_n),
`endif
        .fifo_rd_en(fifo_rd_en),
        .tx_busy(tx_busy),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .sched_busy(sched_busy),
        .flush_done(flush_done),
        .frames_sent(frames_sent),
        .lowwm_irq(lowwm_irq)
    );

    always #5 clk = ~clk;

    // FIFO model: writer pointer owned by the stimulus, reader by the model
    logic [7:0] mem [256];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    logic [7:0] occ;
    logic       wm_mode = 1'b0;
    logic [6:0] wm_cnt = 7'd0;

    assign occ        = wr_ptr - rd_ptr;
    assign fifo_empty = (occ == 8'd0);
    assign fifo_count = wm_mode ? wm_cnt : occ[6:0];

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    // transmitter model: busy for 10 cycles after each launch
    logic [3:0] busy_cnt = 4'd0;
    logic       busy_force = 1'b0;

    assign tx_busy = (busy_cnt != 4'd0) || busy_force;

    always @(posedge clk) begin
        if (tx_start) begin
            busy_cnt <= 4'd10;
        end else if (busy_cnt != 4'd0) begin
            busy_cnt <= busy_cnt - 4'd1;
        end
    end

    // event monitor, sampling settled pre-edge values
    int         cyc = 0;
    int         start_cyc[$];
    logic [7:0] start_dat[$];
    int         rd_cnt = 0;
    int         rd_cyc = -1;
    int         fd_cnt = 0;
    int         irq_cnt = 0;
    int         irq_cyc = -1;
    int         bad_rd = 0;

    always @(posedge clk) begin
        if (tx_start) begin
            start_cyc.push_back(cyc);
            start_dat.push_back(tx_data);
        end
        if (fifo_rd_en) begin
            rd_cnt = rd_cnt + 1;
            rd_cyc = cyc;
            if (fifo_empty) bad_rd = bad_rd + 1;
        end
        if (flush_done) fd_cnt = fd_cnt + 1;
        if (lowwm_irq) begin
            irq_cnt = irq_cnt + 1;
            irq_cyc = cyc;
        end
        cyc = cyc + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic wait_frames(input int tgt, input int lim);
        int k = 0;
        while (frames_sent != 16'(tgt) && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("frames_reached", 32'(frames_sent), 32'(tgt));
    endtask

    task automatic wait_idle(input int lim);
        int k = 0;
        while (sched_busy && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", 32'(sched_busy), 32'd0);
    endtask

    task automatic wait_starts(input int tgt, input int lim);
        int k = 0;
        while (start_cyc.size() < tgt && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("start_seen", 32'(start_cyc.size()), 32'(tgt));
    endtask

    task automatic wait_fd(input int tgt, input int lim);
        int k = 0;
        while (fd_cnt < tgt && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("flush_done_seen", 32'(fd_cnt), 32'(tgt));
    endtask

    typedef struct {
        logic       en;
        logic       rd;
        logic       st;
        logic       sb;
        logic [7:0] dat;
    } vec_t;

    vec_t vt[6];

    initial begin
        int s0, r0, f0, d0, i0, c8;

        vt[0] = '{en: 1'b1, rd: 1'b0, st: 1'b0, sb: 1'b0, dat: 8'h00};
        vt[1] = '{en: 1'b1, rd: 1'b1, st: 1'b0, sb: 1'b1, dat: 8'h00};
        vt[2] = '{en: 1'b1, rd: 1'b0, st: 1'b0, sb: 1'b1, dat: 8'h00};
        vt[3] = '{en: 1'b1, rd: 1'b0, st: 1'b1, sb: 1'b1, dat: 8'h55};
        vt[4] = '{en: 1'b1, rd: 1'b0, st: 1'b0, sb: 1'b1, dat: 8'h55};
        vt[5] = '{en: 1'b1, rd: 1'b0, st: 1'b0, sb: 1'b1, dat: 8'h55};

        rst    = 1'b1;
        enable = 1'b0;
        flush  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_sched_busy", 32'(sched_busy), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_frames", 32'(frames_sent), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_flush_done", 32'(flush_done), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        repeat (5) @(negedge clk);
        chk("no_irq_after_rst", 32'(irq_cnt), 32'd0);

        // launch latency and first frame, cycle by cycle
        push(8'h55);
        push(8'hA3);
        push(8'hFF);
        for (int i = 0; i < 6; i++) begin
            enable = vt[i].en;
            #1;
            chk($sformatf("vec%0d_rd", i), 32'(fifo_rd_en), 32'(vt[i].rd));
            chk($sformatf("vec%0d_st", i), 32'(tx_start), 32'(vt[i].st));
            chk($sformatf("vec%0d_sb", i), 32'(sched_busy), 32'(vt[i].sb));
            chk($sformatf("vec%0d_dat", i), 32'(tx_data), 32'(vt[i].dat));
            @(negedge clk);
        end
        wait_frames(3, 300);
        wait_idle(60);
        chk("seq_n_starts", 32'(start_cyc.size()), 32'd3);
        if (start_cyc.size() >= 3) begin
            chk("seq_byte0", 32'(start_dat[0]), 32'h55);
            chk("seq_byte1", 32'(start_dat[1]), 32'hA3);
            chk("seq_byte2", 32'(start_dat[2]), 32'hFF);
            chk("period_01", 32'(start_cyc[1] - start_cyc[0]), 32'(PERIOD));
            chk("period_12", 32'(start_cyc[2] - start_cyc[1]), 32'(PERIOD));
        end

        // transmitter still busy when START is reached
        busy_force = 1'b1;
        push(8'h3C);
        repeat (8) @(negedge clk);
        chk("held_no_start", 32'(start_cyc.size()), 32'd3);
        chk("held_busy", 32'(sched_busy), 32'd1);
        chk("held_data", 32'(tx_data), 32'h3C);
        busy_force = 1'b0;
        #1;
        chk("release_start", 32'(tx_start), 32'd1);
        chk("release_data", 32'(tx_data), 32'h3C);
        @(negedge clk);
        wait_frames(4, 100);
        wait_idle(60);

        // flush requested during the first of five queued frames
        enable = 1'b0;
        for (int i = 1; i <= 5; i++) push(8'(i));
        s0 = start_cyc.size();
        r0 = rd_cnt;
        d0 = fd_cnt;
        enable = 1'b1;
        wait_starts(s0 + 1, 20);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_fd(d0 + 1, 100);
        repeat (40) @(negedge clk);
        chk("flush_frames", 32'(frames_sent), 32'd5);
        chk("flush_rd_total", 32'(rd_cnt - r0), 32'd5);
        chk("flush_done_once", 32'(fd_cnt - d0), 32'd1);
        chk("flush_no_start", 32'(start_cyc.size() - s0), 32'd1);
        chk("flush_empty", 32'(occ), 32'd0);

        // enable dropped mid-frame leaves the rest queued
        enable = 1'b0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        s0 = start_cyc.size();
        r0 = rd_cnt;
        f0 = int'(frames_sent);
        enable = 1'b1;
        wait_starts(s0 + 1, 20);
        enable = 1'b0;
        wait_idle(60);
        repeat (20) @(negedge clk);
        chk("stop_frames", 32'(frames_sent), 32'(f0 + 1));
        chk("stop_occ", 32'(occ), 32'd2);
        chk("stop_rd", 32'(rd_cnt - r0), 32'd1);
        chk("stop_idle", 32'(sched_busy), 32'd0);
        enable = 1'b1;
        wait_frames(f0 + 3, 200);
        wait_idle(60);
        if (start_cyc.size() >= s0 + 3) begin
            chk("resume_b1", 32'(start_dat[s0 + 1]), 32'h22);
            chk("resume_b2", 32'(start_dat[s0 + 2]), 32'h33);
        end
        chk("resume_occ", 32'(occ), 32'd0);

        // watermark crossing 10 -> 9 -> 8 -> 7
        enable = 1'b0;
        wm_cnt = 7'd10;
        wm_mode = 1'b1;
        repeat (3) @(negedge clk);
        i0 = irq_cnt;
        wm_cnt = 7'd9;
        @(negedge clk);
        wm_cnt = 7'd8;
        c8 = cyc;
        @(negedge clk);
        wm_cnt = 7'd7;
        repeat (5) @(negedge clk);
        chk("wm_once", 32'(irq_cnt - i0), 32'd1);
        chk("wm_cycle", 32'(irq_cyc), 32'(c8 + 1));
        wm_mode = 1'b0;
        repeat (3) @(negedge clk);

        // reset in the middle of a frame
        push(8'h77);
        enable = 1'b1;
        s0 = start_cyc.size();
        wait_starts(s0 + 1, 20);
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_busy", 32'(sched_busy), 32'd0);
        chk("mrst_frames", 32'(frames_sent), 32'd0);
        chk("mrst_data", 32'(tx_data), 32'd0);
        i0 = irq_cnt;
        repeat (15) @(negedge clk);
        chk("mrst_no_irq", 32'(irq_cnt - i0), 32'd0);

`ifdef UART_TX_SCHED_CTS_EN
        // clear-to-send gating
        cts_n = 1'b1;
        repeat (4) @(negedge clk);
        push(8'h5A);
        r0 = rd_cnt;
        enable = 1'b1;
        repeat (10) @(negedge clk);
        chk("cts_block", 32'(rd_cnt - r0), 32'd0);
        cts_n = 1'b0;
        c8 = cyc;
        repeat (6) @(negedge clk);
        chk("cts_rd_once", 32'(rd_cnt - r0), 32'd1);
        chk("cts_rd_cycle", 32'(rd_cyc), 32'(c8 + 3));
        wait_idle(60);
        enable = 1'b0;
`endif

        chk("rd_while_empty", 32'(bad_rd), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
